// File: rtl/reset_sequencer_if.sv
// -----------------------------------------------------------------------------
// reset_sequencer_if
// Bundles the control/status signals of the central reset sequencer.
//   i_soft_reset_req : one-cycle pulse restarting the whole sequence
//   i_pll_locked     : raw PLL lock, asynchronous to the sequencer clock
//   o_pll_reset      : PLL reset, active high
//   o_domain_reset_n : per-domain reset request, active low
//   o_ready          : all domains released and lock stable
//   o_fault          : retry budget exhausted
//   o_state          : current state code
//   o_retry_count    : failed attempts since last RUN / soft reset
// master = the sequencer, slave = the surrounding SoC / LED logic.
// N_DOMAINS must match the N_DOMAINS of the attached sequencer.
// -----------------------------------------------------------------------------
interface reset_sequencer_if #(
    parameter int N_DOMAINS = 3
);
    logic                 i_soft_reset_req;
    logic                 i_pll_locked;
    logic                 o_pll_reset;
    logic [N_DOMAINS-1:0] o_domain_reset_n;
    logic                 o_ready;
    logic                 o_fault;
    logic [2:0]           o_state;
    logic [7:0]           o_retry_count;

    modport master (
        input  i_soft_reset_req, i_pll_locked,
        output o_pll_reset, o_domain_reset_n, o_ready, o_fault, o_state, o_retry_count
    );

    modport slave (
        output i_soft_reset_req, i_pll_locked,
        input  o_pll_reset, o_domain_reset_n, o_ready, o_fault, o_state, o_retry_count
    );
endinterface

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
// Central reset controller on the free-running quartz clock. Pulses the PLL
// reset, qualifies lock (timeout + stability window), then releases the
// per-domain reset requests in index order with a fixed gap. Any lock loss
// counts as a failed attempt and restarts the sequence; after MAX_RETRIES
// consecutive failures it parks in FAULT until a soft or hard reset.
// Ports:
//   i_clk     : quartz clock
//   i_reset_n : asynchronous active-low reset
//   bus       : reset_sequencer_if.master (soft reset, lock in; status out)
// -----------------------------------------------------------------------------
module reset_sequencer #(
    parameter int N_DOMAINS           = 3,
    parameter int PLL_RESET_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 25_000_000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int DOMAIN_GAP_CYCLES   = 8,
    parameter int MAX_RETRIES         = 3
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    reset_sequencer_if.master bus
);
    localparam logic [2:0] S_PLL_RST   = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RELEASE   = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;
    localparam logic [2:0] S_FAULT     = 3'd5;

    localparam int PLL_W = (PLL_RESET_CYCLES    > 1) ? $clog2(PLL_RESET_CYCLES)    : 1;
    localparam int TO_W  = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
    localparam int STB_W = (LOCK_STABLE_CYCLES  > 1) ? $clog2(LOCK_STABLE_CYCLES)  : 1;
    localparam int GAP_W = (DOMAIN_GAP_CYCLES   > 1) ? $clog2(DOMAIN_GAP_CYCLES)   : 1;
    localparam int IDX_W = $clog2(N_DOMAINS + 1);

    localparam logic [PLL_W-1:0] PLL_LAST = PLL_W'(PLL_RESET_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(DOMAIN_GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_DONE = IDX_W'(N_DOMAINS);
    localparam logic [7:0]       MAX_R    = 8'(MAX_RETRIES);
    localparam bit               FOREVER  = (MAX_RETRIES == 0);

    logic                 lock_p0_q, lock_p1_q;
    logic [2:0]           state_q, state_d;
    logic [PLL_W-1:0]     pll_cnt_q, pll_cnt_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic [STB_W-1:0]     stb_cnt_q, stb_cnt_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N_DOMAINS-1:0] dom_q, dom_d;
    logic                 pll_rst_q, pll_rst_d;
    logic                 ready_q, ready_d;
    logic                 fault_q, fault_d;
    logic [7:0]           retry_q, retry_d;
    logic [7:0]           retry_inc;
    logic                 fail;
    logic                 lock_s;

    assign lock_s = lock_p1_q;

    // Counters default to zero, so every counter is already clear when its
    // state is entered; only the owning state holds or advances it.
    always_comb begin
        state_d   = state_q;
        pll_cnt_d = '0;
        to_cnt_d  = '0;
        stb_cnt_d = '0;
        gap_cnt_d = '0;
        idx_d     = '0;
        dom_d     = dom_q;
        pll_rst_d = pll_rst_q;
        ready_d   = ready_q;
        fault_d   = fault_q;
        retry_d   = retry_q;
        fail      = 1'b0;
        retry_inc = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;

        case (state_q)
            S_PLL_RST: begin
                if (pll_cnt_q == PLL_LAST) begin
                    state_d   = S_WAIT_LOCK;
                    pll_rst_d = 1'b0;
                end else begin
                    pll_cnt_d = pll_cnt_q + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s)                   state_d  = S_STABLE;
                else if (to_cnt_q == TO_LAST) fail     = 1'b1;
                else                          to_cnt_d = to_cnt_q + 1'b1;
            end
            S_STABLE: begin
                if (!lock_s)                    fail      = 1'b1;
                else if (stb_cnt_q == STB_LAST) state_d   = S_RELEASE;
                else                            stb_cnt_d = stb_cnt_q + 1'b1;
            end
            S_RELEASE: begin
                // Lock loss wins over a release due this cycle, so no domain
                // is ever released while lock_s is low.
                if (!lock_s) begin
                    fail = 1'b1;
                end else if (idx_q == IDX_DONE) begin
                    state_d = S_RUN;
                    ready_d = 1'b1;
                    retry_d = 8'd0;
                end else if (gap_cnt_q == GAP_LAST) begin
                    for (int i = 0; i < N_DOMAINS; i++)
                        if (idx_q == IDX_W'(i)) dom_d[i] = 1'b1;
                    idx_d = idx_q + 1'b1;
                end else begin
                    idx_d     = idx_q;
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                ready_d = 1'b1;
                retry_d = 8'd0;
                if (!lock_s) fail = 1'b1;
            end
            S_FAULT: begin
                pll_rst_d = 1'b1;
                dom_d     = '0;
                fault_d   = 1'b1;
            end
            default: begin
                state_d   = S_PLL_RST;
                pll_rst_d = 1'b1;
                dom_d     = '0;
                ready_d   = 1'b0;
            end
        endcase

        if (fail) begin
            dom_d     = '0;
            ready_d   = 1'b0;
            pll_rst_d = 1'b1;
            retry_d   = retry_inc;
            if (!FOREVER && retry_inc == MAX_R) begin
                state_d = S_FAULT;
                fault_d = 1'b1;
            end else begin
                state_d = S_PLL_RST;
            end
        end

        if (bus.i_soft_reset_req) begin
            state_d   = S_PLL_RST;
            pll_cnt_d = '0;
            to_cnt_d  = '0;
            stb_cnt_d = '0;
            gap_cnt_d = '0;
            idx_d     = '0;
            dom_d     = '0;
            pll_rst_d = 1'b1;
            ready_d   = 1'b0;
            fault_d   = 1'b0;
            retry_d   = 8'd0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            lock_p0_q <= 1'b0;
            lock_p1_q <= 1'b0;
            state_q   <= S_PLL_RST;
            pll_cnt_q <= '0;
            to_cnt_q  <= '0;
            stb_cnt_q <= '0;
            gap_cnt_q <= '0;
            idx_q     <= '0;
            dom_q     <= '0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
            retry_q   <= 8'd0;
        end else begin
            // two-flop synchronizer for the asynchronous lock input
            lock_p0_q <= bus.i_pll_locked;
            lock_p1_q <= lock_p0_q;
            state_q   <= state_d;
            pll_cnt_q <= pll_cnt_d;
            to_cnt_q  <= to_cnt_d;
            stb_cnt_q <= stb_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            idx_q     <= idx_d;
            dom_q     <= dom_d;
            pll_rst_q <= pll_rst_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
            retry_q   <= retry_d;
        end
    end

    assign bus.o_pll_reset      = pll_rst_q;
    assign bus.o_domain_reset_n = dom_q;
    assign bus.o_ready          = ready_q;
    assign bus.o_fault          = fault_q;
    assign bus.o_state          = state_q;
    assign bus.o_retry_count    = retry_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
// Two sequencer instances: dut_a with default parameters (lock driven by the
// bench) and dut_b with a 50-cycle lock timeout and lock never asserted.
// Directed steps sampled on the falling clock edge; each step compares all
// status outputs against hand-derived values.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;
    logic clk;
    logic rst_a_n;
    logic rst_b_n;
    int   n_cmp;
    int   n_err;

    reset_sequencer_if #(.N_DOMAINS(3)) bus_a ();
    reset_sequencer_if #(.N_DOMAINS(3)) bus_b ();

    reset_sequencer #(.N_DOMAINS(3)) dut_a (
        .i_clk     (clk),
        .i_reset_n (rst_a_n),
        .bus       (bus_a)
    );

    reset_sequencer #(
        .N_DOMAINS           (3),
        .LOCK_TIMEOUT_CYCLES (50),
        .MAX_RETRIES         (3)
    ) dut_b (
        .i_clk     (clk),
        .i_reset_n (rst_b_n),
        .bus       (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic pll, input logic [2:0] dom,
                         input logic rdy, input logic flt, input logic [2:0] st,
                         input logic [7:0] rc);
        cmp({tag, ".pll_reset"}, 32'(bus_a.o_pll_reset),      32'(pll));
        cmp({tag, ".domains"},   32'(bus_a.o_domain_reset_n), 32'(dom));
        cmp({tag, ".ready"},     32'(bus_a.o_ready),          32'(rdy));
        cmp({tag, ".fault"},     32'(bus_a.o_fault),          32'(flt));
        cmp({tag, ".state"},     32'(bus_a.o_state),          32'(st));
        cmp({tag, ".retries"},   32'(bus_a.o_retry_count),    32'(rc));
    endtask

    task automatic chk_b(input string tag, input logic pll, input logic [2:0] dom,
                         input logic rdy, input logic flt, input logic [2:0] st,
                         input logic [7:0] rc);
        cmp({tag, ".pll_reset"}, 32'(bus_b.o_pll_reset),      32'(pll));
        cmp({tag, ".domains"},   32'(bus_b.o_domain_reset_n), 32'(dom));
        cmp({tag, ".ready"},     32'(bus_b.o_ready),          32'(rdy));
        cmp({tag, ".fault"},     32'(bus_b.o_fault),          32'(flt));
        cmp({tag, ".state"},     32'(bus_b.o_state),          32'(st));
        cmp({tag, ".retries"},   32'(bus_b.o_retry_count),    32'(rc));
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        bus_a.i_pll_locked     = 1'b0;
        bus_a.i_soft_reset_req = 1'b0;
        bus_b.i_pll_locked     = 1'b0;
        bus_b.i_soft_reset_req = 1'b0;

        tick(3);
        chk_a("a_reset", 1'b1, 3'b000, 1'b0, 1'b0, 3'd0, 8'd0);
        chk_b("b_reset", 1'b1, 3'b000, 1'b0, 1'b0, 3'd0, 8'd0);

        // dut_b: lock never arrives, three timeouts end in FAULT
        rst_b_n = 1'b1;
        tick(15); chk_b("b_pll1_hi",   1'b1, 3'b000, 1'b0, 1'b0, 3'd0, 8'd0);
        tick(1);  chk_b("b_wait1",     1'b0, 3'b000, 1'b0, 1'b0, 3'd1, 8'd0);
        tick(49); chk_b("b_to1_last",  1'b0, 3'b000, 1'b0, 1'b0, 3'd1, 8'd0);
        tick(1);  chk_b("b_fail1",     1'b1, 3'b000, 1'b0, 1'b0, 3'd0, 8'd1);
        tick(15); chk_b("b_pll2_hi",   1'b1, 3'b000, 1'b0, 1'b0, 3'd0, 8'd1);
        tick(1);  chk_b("b_wait2",     1'b0, 3'b000, 1'b0, 1'b0, 3'd1, 8'd1);
        tick(50); chk_b("b_fail2",     1'b1, 3'b000, 1'b0, 1'b0, 3'd0, 8'd2);
        tick(16); chk_b("b_wait3",     1'b0, 3'b000, 1'b0, 1'b0, 3'd1, 8'd2);
        tick(49); chk_b("b_to3_last",  1'b0, 3'b000, 1'b0, 1'b0, 3'd1, 8'd2);
        tick(1);  chk_b("b_fault",     1'b1, 3'b000, 1'b0, 1'b1, 3'd5, 8'd3);
        tick(20); chk_b("b_fault_hold",1'b1, 3'b000, 1'b0, 1'b1, 3'd5, 8'd3);
        bus_b.i_soft_reset_req = 1'b1;
        tick(1);
        bus_b.i_soft_reset_req = 1'b0;
        chk_b("b_soft_fault", 1'b1, 3'b000, 1'b0, 1'b0, 3'd0, 8'd0);
        rst_b_n = 1'b0;

        // dut_a: power-up, lock 100 cycles after reset release
        rst_a_n = 1'b1;
        tick(15);   chk_a("a_pll_hi",     1'b1, 3'b000, 1'b0, 1'b0, 3'd0, 8'd0);
        tick(1);    chk_a("a_wait",       1'b0, 3'b000, 1'b0, 1'b0, 3'd1, 8'd0);
        tick(84);   chk_a("a_wait_late",  1'b0, 3'b000, 1'b0, 1'b0, 3'd1, 8'd0);
        bus_a.i_pll_locked = 1'b1;
        tick(2);    chk_a("a_sync_lag",   1'b0, 3'b000, 1'b0, 1'b0, 3'd1, 8'd0);
        tick(1);    chk_a("a_stable",     1'b0, 3'b000, 1'b0, 1'b0, 3'd2, 8'd0);
        tick(1023); chk_a("a_stable_end", 1'b0, 3'b000, 1'b0, 1'b0, 3'd2, 8'd0);
        tick(1);    chk_a("a_release",    1'b0, 3'b000, 1'b0, 1'b0, 3'd3, 8'd0);
        tick(7);    chk_a("a_d0_pre",     1'b0, 3'b000, 1'b0, 1'b0, 3'd3, 8'd0);
        tick(1);    chk_a("a_d0",         1'b0, 3'b001, 1'b0, 1'b0, 3'd3, 8'd0);
        tick(7);    chk_a("a_d1_pre",     1'b0, 3'b001, 1'b0, 1'b0, 3'd3, 8'd0);
        tick(1);    chk_a("a_d1",         1'b0, 3'b011, 1'b0, 1'b0, 3'd3, 8'd0);
        tick(8);    chk_a("a_d2",         1'b0, 3'b111, 1'b0, 1'b0, 3'd3, 8'd0);
        tick(1);    chk_a("a_run",        1'b0, 3'b111, 1'b1, 1'b0, 3'd4, 8'd0);
        tick(5);    chk_a("a_run_hold",   1'b0, 3'b111, 1'b1, 1'b0, 3'd4, 8'd0);

        // one-cycle lock drop in RUN
        bus_a.i_pll_locked = 1'b0;
        tick(1);
        bus_a.i_pll_locked = 1'b1;
        tick(1);    chk_a("a_drop_lag",   1'b0, 3'b111, 1'b1, 1'b0, 3'd4, 8'd0);
        tick(1);    chk_a("a_drop_fail",  1'b1, 3'b000, 1'b0, 1'b0, 3'd0, 8'd1);
        tick(1065); chk_a("a_rerelease",  1'b0, 3'b111, 1'b0, 1'b0, 3'd3, 8'd1);
        tick(1);    chk_a("a_rerun",      1'b0, 3'b111, 1'b1, 1'b0, 3'd4, 8'd0);

        // soft reset from RUN, then a lock glitch at stable count 500
        bus_a.i_soft_reset_req = 1'b1;
        tick(1);
        bus_a.i_soft_reset_req = 1'b0;
        chk_a("a_soft_run", 1'b1, 3'b000, 1'b0, 1'b0, 3'd0, 8'd0);
        tick(515);  chk_a("a_glitch_pre", 1'b0, 3'b000, 1'b0, 1'b0, 3'd2, 8'd0);
        bus_a.i_pll_locked = 1'b0;
        tick(1);
        bus_a.i_pll_locked = 1'b1;
        tick(1);    chk_a("a_glitch_lag", 1'b0, 3'b000, 1'b0, 1'b0, 3'd2, 8'd0);
        tick(1);    chk_a("a_glitch_fail",1'b1, 3'b000, 1'b0, 1'b0, 3'd0, 8'd1);

        // soft reset mid-RELEASE with domain 0 released
        tick(1048); chk_a("a_rel2_pre",   1'b0, 3'b000, 1'b0, 1'b0, 3'd3, 8'd1);
        tick(1);    chk_a("a_rel2_d0",    1'b0, 3'b001, 1'b0, 1'b0, 3'd3, 8'd1);
        bus_a.i_soft_reset_req = 1'b1;
        tick(1);
        bus_a.i_soft_reset_req = 1'b0;
        chk_a("a_soft_rel", 1'b1, 3'b000, 1'b0, 1'b0, 3'd0, 8'd0);

        // asynchronous hard reset mid-RELEASE, checked before the next edge
        tick(1057); chk_a("a_rel3_d1",    1'b0, 3'b011, 1'b0, 1'b0, 3'd3, 8'd0);
        #2 rst_a_n = 1'b0;
        #1 chk_a("a_async_rst", 1'b1, 3'b000, 1'b0, 1'b0, 3'd0, 8'd0);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
